// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1 on load, one rotation plus PC-2 per round, valid/ready to the round controller.
// Optional weak-key flag built only when DES_WEAK_KEY_DETECT_EN is defined; otherwise weak_key is tied low.
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        flush,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        weak_key
);

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUND_W  = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    // DES bit n (1-based, MSB first) lives at vector index WIDTH-n
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < SUBKEY_W; i++) begin
            k[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return k;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[0], x[HALF_W-1:1]};
            2'd2:    return {x[1:0], x[HALF_W-1:2]};
            default: return x;
        endcase
    endfunction

    // Decrypt walks the encrypt schedule backwards, starting from the 28-shift identity point
    function automatic logic [1:0] shift_amt(input logic [ROUND_W-1:0] rnd, input logic dec);
        if (dec) begin
            if (rnd == 4'd0) return 2'd0;
            if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) return 2'd1;
            return 2'd2;
        end
        if (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) return 2'd1;
        return 2'd2;
    endfunction

    state_e                state_q, state_d;
    logic [HALF_W-1:0]     c_half_q, c_half_d;
    logic [HALF_W-1:0]     d_half_q, d_half_d;
    logic [SUBKEY_W-1:0]   subkey_q, subkey_d;
    logic                  valid_q, valid_d;
    logic [ROUND_W-1:0]    round_q, round_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  dec_q, dec_d;

    logic [CD_W-1:0]       cd_load;
    logic [1:0]            amt;
    logic [HALF_W-1:0]     c_rot, d_rot;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_half_q <= '0;
            d_half_q <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_half_q <= c_half_d;
            d_half_q <= d_half_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            round_q  <= round_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dec_q    <= dec_d;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (key_load) state_d = S_ROT;
                S_ROT:  state_d = S_WAIT;
                S_WAIT: if (subkey_ready) state_d = (round_q == LAST_ROUND) ? S_IDLE : S_ROT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_comb begin
        cd_load  = pc1(key_in);
        amt      = shift_amt(round_q, dec_q);
        c_rot    = dec_q ? rotr(c_half_q, amt) : rotl(c_half_q, amt);
        d_rot    = dec_q ? rotr(d_half_q, amt) : rotl(d_half_q, amt);
        c_half_d = c_half_q;
        d_half_d = d_half_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        round_d  = round_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        dec_d    = dec_q;
        if (flush) begin
            valid_d = 1'b0;
            round_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_load) begin
                        c_half_d = cd_load[CD_W-1:HALF_W];
                        d_half_d = cd_load[HALF_W-1:0];
                        dec_d    = decrypt;
                        round_d  = '0;
                        busy_d   = 1'b1;
                    end
                end
                S_ROT: begin
                    c_half_d = c_rot;
                    d_half_d = d_rot;
                    subkey_d = pc2({c_rot, d_rot});
                    valid_d  = 1'b1;
                end
                S_WAIT: begin
                    if (subkey_ready) begin
                        valid_d = 1'b0;
                        if (round_q == LAST_ROUND) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DES_WEAK_KEY_DETECT_EN
    logic weak_q, weak_d;

    // Weak when each PC-1 half is uniform; only a real load updates the flag
    always_comb begin
        weak_d = weak_q;
        if (!flush && state_q == S_IDLE && key_load) begin
            weak_d = ((&cd_load[CD_W-1:HALF_W]) | ~(|cd_load[CD_W-1:HALF_W])) &
                     ((&cd_load[HALF_W-1:0])    | ~(|cd_load[HALF_W-1:0]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) weak_q <= 1'b0;
        else        weak_q <= weak_d;
    end

    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed scenarios plus random traffic against a cycle-level schedule model.
module tb_des_key_schedule;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        flush = 1'b0;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic        weak_key;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_keys [16];
    logic [3:0]  exp_round = '0;
    logic        exp_valid = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_weak = 1'b0;
    int          rise = 0;

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .decrypt(decrypt), .flush(flush), .subkey(subkey), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .round_idx(round_idx), .busy(busy), .done(done),
        .weak_key(weak_key)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [55:0] model_pc1(input logic [63:0] key);
        logic [55:0] cd;
        for (int j = 0; j < 56; j++) cd[6'(55 - j)] = key[6'(64 - PC1[j])];
        return cd;
    endfunction

    // Subkey K(rnd+1): cumulative left shift of the PC-1 halves, then PC-2
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int rnd);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int total;
        cd = model_pc1(key);
        c = cd[55:28];
        d = cd[27:0];
        total = 0;
        for (int r = 0; r <= rnd; r++) total += SHIFTS[r];
        for (int n = 0; n < total; n++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
        return k;
    endfunction

    function automatic logic model_weak(input logic [63:0] key);
        logic [55:0] cd;
        cd = model_pc1(key);
        return (cd[55:28] == 28'h0 || cd[55:28] == 28'hFFFFFFF) &&
               (cd[27:0] == 28'h0 || cd[27:0] == 28'hFFFFFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle model: checks outputs every negedge, then applies the inputs the next edge will sample
    task automatic monitor_loop();
        logic nxt_done;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valid", 64'(subkey_valid), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                check("rst_round", 64'(round_idx), 64'(0));
                check("rst_subkey", 64'(subkey), 64'(0));
                check("rst_weak", 64'(weak_key), 64'(0));
                exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
                exp_weak = 1'b0; exp_round = '0; rise = 0;
            end else begin
                check("valid", 64'(subkey_valid), 64'(exp_valid));
                check("busy", 64'(busy), 64'(exp_busy));
                check("done", 64'(done), 64'(exp_done));
                check("weak", 64'(weak_key), 64'(exp_weak));
                if (exp_valid) begin
                    check("round_idx", 64'(round_idx), 64'(exp_round));
                    check("subkey", 64'(subkey), 64'(exp_keys[exp_round]));
                end
                nxt_done = 1'b0;
                if (flush) begin
                    exp_valid = 1'b0; exp_busy = 1'b0; exp_round = '0; rise = 0;
                end else if (!exp_busy) begin
                    if (key_load) begin
                        for (int i = 0; i < 16; i++)
                            exp_keys[i] = model_subkey(key_in, decrypt ? 15 - i : i);
`ifdef DES_WEAK_KEY_DETECT_EN
                        exp_weak = model_weak(key_in);
`else
                        exp_weak = 1'b0;
`endif
                        exp_busy = 1'b1; exp_round = '0; rise = 2;
                    end
                end else if (exp_valid && subkey_ready) begin
                    exp_valid = 1'b0;
                    if (exp_round == 4'd15) begin
                        nxt_done = 1'b1;
                        exp_busy = 1'b0;
                    end else begin
                        exp_round = exp_round + 4'd1;
                        rise = 2;
                    end
                end
                exp_done = nxt_done;
                if (rise > 0) begin
                    rise--;
                    if (rise == 0) exp_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic load(input logic [63:0] key, input logic dec);
        key_in = key;
        decrypt = dec;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r, input string name);
        int n = 0;
        while (!(subkey_valid && round_idx == r) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(subkey_valid && round_idx == r), 64'(1));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(done), 64'(1));
    endtask

    task automatic random_phase(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            subkey_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 149) == 0);
            key_load = ($urandom_range(0, 19) == 0);
            decrypt = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: key_in = 64'h0101010101010101;
                1: key_in = 64'hFEFEFEFEFEFEFEFE;
                2: key_in = 64'h1F1F1F1F0E0E0E0E;
                default: key_in = {$urandom, $urandom};
            endcase
            tick();
        end
        flush = 1'b0;
        key_load = 1'b0;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Literal pins on the model itself
        check("pin_k1", 64'(model_subkey(64'h133457799BBCDFF1, 0)), 64'h1B02EFFC7072);
        check("pin_k2", 64'(model_subkey(64'h133457799BBCDFF1, 1)), 64'h79AED9DBC9E5);
        check("pin_k16", 64'(model_subkey(64'h133457799BBCDFF1, 15)), 64'hCB3D8B0E17F5);
        check("pin_weak0", 64'(model_subkey(64'h0101010101010101, 5)), 64'h0);
        check("pin_weak1", 64'(model_subkey(64'hFEFEFEFEFEFEFEFE, 9)), 64'hFFFFFFFFFFFF);
        check("pin_isweak", 64'(model_weak(64'h1F1F1F1F0E0E0E0E)), 64'(1));
        check("pin_notweak", 64'(model_weak(64'h133457799BBCDFF1)), 64'(0));

        repeat (3) tick();
        check("reset_valid", 64'(subkey_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_subkey", 64'(subkey), 64'(0));
        rst_n = 1'b1;
        tick();

        // Encrypt with ready held high
        subkey_ready = 1'b1;
        load(64'h133457799BBCDFF1, 1'b0);
        check("lat_edge1_valid", 64'(subkey_valid), 64'(0));
        check("lat_edge1_busy", 64'(busy), 64'(1));
        tick();
        check("lat_edge2_valid", 64'(subkey_valid), 64'(1));
        check("enc_k1", 64'(subkey), 64'h1B02EFFC7072);
        wait_round(4'd1, "enc_wait_r1");
        check("enc_k2", 64'(subkey), 64'h79AED9DBC9E5);
        wait_round(4'd15, "enc_wait_r15");
        check("enc_k16", 64'(subkey), 64'hCB3D8B0E17F5);
        wait_done("enc_done");
        check("enc_done_busy", 64'(busy), 64'(0));
        tick();
        check("enc_done_pulse", 64'(done), 64'(0));

        // Decrypt order
        load(64'h133457799BBCDFF1, 1'b1);
        wait_round(4'd0, "dec_wait_r0");
        check("dec_k16_first", 64'(subkey), 64'hCB3D8B0E17F5);
        wait_round(4'd15, "dec_wait_r15");
        check("dec_k1_last", 64'(subkey), 64'h1B02EFFC7072);
        wait_done("dec_done");
        tick();

        // Backpressure at round 3
        load({$urandom, $urandom}, 1'b0);
        wait_round(4'd3, "bp_wait_r3");
        subkey_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(subkey_valid), 64'(1));
            check("bp_hold_round", 64'(round_idx), 64'(3));
        end
        subkey_ready = 1'b1;
        tick();
        check("bp_accept_valid", 64'(subkey_valid), 64'(0));
        tick();
        check("bp_r4_valid", 64'(subkey_valid), 64'(1));
        check("bp_r4_round", 64'(round_idx), 64'(4));
        wait_done("bp_done");
        tick();

        // Weak keys
        load(64'h0101010101010101, 1'b0);
        wait_round(4'd7, "weak0_wait");
        check("weak0_subkey", 64'(subkey), 64'h0);
`ifdef DES_WEAK_KEY_DETECT_EN
        check("weak0_flag", 64'(weak_key), 64'(1));
`else
        check("weak0_flag", 64'(weak_key), 64'(0));
`endif
        wait_done("weak0_done");
        tick();
        load(64'hFEFEFEFEFEFEFEFE, 1'b1);
        wait_round(4'd2, "weak1_wait");
        check("weak1_subkey", 64'(subkey), 64'hFFFFFFFFFFFF);
        wait_done("weak1_done");
        tick();

        // Flush at round 7, then reload with ignored key_load pulses while busy
        load({$urandom, $urandom}, 1'b0);
        wait_round(4'd7, "flush_wait_r7");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(subkey_valid), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_round", 64'(round_idx), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        load(64'h133457799BBCDFF1, 1'b0);
        key_in = {$urandom, $urandom};
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        wait_round(4'd0, "reload_wait_r0");
        check("reload_k1", 64'(subkey), 64'h1B02EFFC7072);
        load(64'h0101010101010101, 1'b1);
        wait_round(4'd1, "reload_wait_r1");
        check("reload_k2", 64'(subkey), 64'h79AED9DBC9E5);
        wait_done("reload_done");
        tick();

        random_phase(3000);
        subkey_ready = 1'b1;
        repeat (40) tick();

        // Asynchronous reset between edges while in WAIT
        subkey_ready = 1'b0;
        load({$urandom, $urandom}, 1'b0);
        wait_round(4'd0, "areset_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(subkey_valid), 64'(0));
        check("areset_busy", 64'(busy), 64'(0));
        check("areset_subkey", 64'(subkey), 64'(0));
        check("areset_round", 64'(round_idx), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        subkey_ready = 1'b1;
        repeat (10) tick();
        check("post_reset_idle_valid", 64'(subkey_valid), 64'(0));
        check("post_reset_idle_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one per round.
- Sits directly upstream of the f-block key XOR. Its subkey is XORed with the expanded R half, and the result feeds the S-box stage.
- Produces subkeys in encrypt order (K1..K16) or decrypt order (K16..K1), with a valid/ready handshake to the round controller.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted per key load. Fixed for DES; values other than 16 are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  load request; sampled only in IDLE
- key_in  input  64  DES key; key_in[63] = DES bit 1; parity bits (DES bits 8,16,...,64) ignored
- decrypt  input  1  direction, latched with key_load; 0 = K1..K16, 1 = K16..K1
- flush  input  1  synchronous abort to IDLE
- subkey  output  48  current round key; subkey[47] = DES bit 1, so subkey[47:42] pairs with S1
- subkey_valid  output  1  subkey holds a valid round key
- subkey_ready  input  1  consumer accepts subkey
- round_idx  output  4  round number of current subkey, 0..15 (first round = 0)
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last subkey is accepted
- weak_key  output  1  see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; C,D=0; subkey=0; subkey_valid=0; round_idx=0; busy=0; done=0; weak_key=0; latched direction=0.
- State IDLE:
  - key_load=1 loads C,D <= PC-1(key_in) (28 bits each), latches decrypt, sets round_idx=0, goes to ROT.
- State ROT (one cycle):
  - Rotate C,D by the rotation amount below and register the rotated values.
  - subkey <= PC-2(rotated C,D); subkey_valid <= 1; go to WAIT.
- State WAIT:
  - Hold subkey, subkey_valid and round_idx stable until subkey_ready=1.
  - On the accepting edge, subkey_valid <= 0.
  - If round_idx=15: done pulses next cycle, then IDLE.
  - Otherwise round_idx increments and the state goes to ROT.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt rotation: before round r (1-based), rotate C and D left by s[r].
- Decrypt rotation:
  - Round 1: no rotation. The 28 total left shifts are the identity, so PC-2(C0,D0)=K16.
  - Round r>=2: rotate right by s[18-r].
- Latency and rate: subkey_valid rises 2 cycles after the key_load edge. Maximum rate is 1 subkey per 2 cycles with subkey_ready held high.
- done is asserted the cycle after the final acceptance; busy falls in the same cycle.
- key_load while busy=1: ignored; no state change.
- flush:
  - Any state, next edge: IDLE, subkey_valid=0, round_idx=0, done=0.
  - C,D and subkey keep their values.
  - flush has priority over key_load and subkey_ready in the same cycle.
- subkey_ready while subkey_valid=0: ignored.
- Reset asserted mid-schedule: immediate return to reset values. No subkey is emitted after rst_n deasserts until a new key_load.

Optional Feature:
- Macro DES_WEAK_KEY_DETECT_EN.
- Defined:
  - In the load cycle, weak_key <= 1 if PC-1 C half is all-0 or all-1 AND PC-1 D half is all-0 or all-1 (the four DES weak keys); otherwise weak_key <= 0.
  - Held until the next accepted key_load or reset. flush does not clear it.
  - The schedule still runs normally.
- Undefined: weak_key is tied 0 and no comparison logic is built.

Test Plan:
- Encrypt: key_in=64'h133457799BBCDFF1, decrypt=0, subkey_ready=1.
  - round 0 subkey=48'h1B02EFFC7072; round 1 subkey=48'h79AED9DBC9E5; round 15 subkey=48'hCB3D8B0E17F5.
  - done pulses once; first subkey_valid 2 cycles after load.
- Decrypt, same key, decrypt=1: round 0 subkey=48'hCB3D8B0E17F5, round 15 subkey=48'h1B02EFFC7072.
- Backpressure: hold subkey_ready=0 for 5 cycles in round 3 -> subkey and round_idx stable, subkey_valid stays 1; release -> round 4 follows 2 cycles later.
- Weak key: key_in=64'h0101010101010101 -> all 16 subkeys 48'h000000000000.
  - With DES_WEAK_KEY_DETECT_EN: weak_key=1.
  - key_in=64'hFEFEFEFEFEFEFEFE -> all subkeys 48'hFFFFFFFFFFFF, weak_key=1.
- Flush and reload: flush at round 7 -> next cycle subkey_valid=0, busy=0. A new key_load restarts from round 0 with the correct K1; key_load pulses during busy have no effect.
- Async reset: drop rst_n mid-WAIT between clock edges -> outputs reach reset values without a clock edge.
